// File: rtl/audio_pkg.sv
// Shared audio sample-path types.
// Default channel-slot width and PCM sample type.
package audio_pkg;

  localparam int SAMPLE_WIDTH = 16;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/i2s_tx_if.sv
// Sample handshake from the gain stage.
// Source drives sample/valid, sink drives ready.
interface i2s_tx_if
  import audio_pkg::*;
#(
  parameter int W = SAMPLE_WIDTH
);

  logic signed [W-1:0] sample;
  logic                valid;
  logic                ready;

  modport master (
    output sample,
    output valid,
    input  ready
  );

  modport slave (
    input  sample,
    input  valid,
    output ready
  );

endinterface

// File: rtl/i2s_clkgen.sv
// I2S bit-clock divider with edge strobes.
// Strobes are high in the cycle before sclk_o changes.
module i2s_clkgen #(
  parameter int SCLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic sclk_o,
  output logic sclk_fall_o,
  output logic sclk_rise_o
);

  localparam int DW =
    (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic [DW-1:0] div_q;
  logic          run_q;
  logic          tc;

  assign tc = (div_q == DW'(SCLK_DIV - 1));

  // Idle SCLK is low, so the first terminal
  // count acts as the falling edge of frame 0.
  assign sclk_fall_o = tc & (sclk_o | ~run_q);
  assign sclk_rise_o = tc & ~sclk_o & run_q;

  // Divider count and SCLK toggle on terminal count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= '0;
      run_q  <= 1'b0;
      sclk_o <= 1'b0;
    end else begin
      div_q <= tc ? '0 : div_q + 1'b1;
      if (tc) begin
        run_q <= 1'b1;
        if (run_q) begin
          sclk_o <= ~sclk_o;
        end
      end
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Mono PCM to Philips I2S stereo serialiser.
// Same sample on both slots, MSB first.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = audio_pkg::SAMPLE_WIDTH,
  parameter int SCLK_DIV     = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  i2s_tx_if.slave    src,
  output logic       sclk_o,
  output logic       lrclk_o,
  output logic       sdata_o,
  output logic       underrun_o
);

  localparam int W  = SAMPLE_WIDTH;
  localparam int BW = $clog2(2 * W);
  localparam int IW = $clog2(W);

  logic          fall;
  logic          unused_rise;
  logic [W-1:0]  hold_q;
  logic          hold_full_q;
  logic [W-1:0]  frame_q;
  logic [W-1:0]  frame_nxt;
  logic [BW-1:0] b_q;
  logic [BW-1:0] b_nxt;
  logic [IW-1:0] idx;
  logic          lr_nxt;
  logic          load;
  logic          accept;

  i2s_clkgen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_clkgen (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .sclk_o      (sclk_o),
    .sclk_fall_o (fall),
    .sclk_rise_o (unused_rise)
  );

  assign src.ready = ~hold_full_q;
  assign accept    = src.valid & ~hold_full_q;

  assign b_nxt = (b_q == BW'(2 * W - 1))
               ? '0 : b_q + 1'b1;
  assign load  = fall & (b_nxt == '0);

  // No bypass: an empty hold at load gives
  // a silent frame even if a sample lands now.
  assign frame_nxt = !load      ? frame_q :
                     hold_full_q ? hold_q  : '0;

  assign lr_nxt = (b_nxt >= BW'(W - 1)) &&
                  (b_nxt <= BW'(2 * W - 2));

  // Slot bit index; modular math is exact
  // because the result always lies in [0,W-1].
  always_comb begin
    idx = IW'(2 * W - 1) - IW'(b_nxt);
    if (b_nxt < BW'(W)) begin
      idx = IW'(W - 1) - IW'(b_nxt);
    end
  end

  // Holding register and underrun flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_o  <= 1'b0;
    end else begin
      underrun_o  <= load & ~hold_full_q;
      hold_full_q <= load ? accept
                          : (hold_full_q | accept);
      if (accept) begin
        hold_q <= src.sample;
      end
    end
  end

  // Serialiser: all pin changes on SCLK fall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_q <= '0;
      b_q     <= BW'(2 * W - 1);
      lrclk_o <= 1'b0;
      sdata_o <= 1'b0;
    end else if (fall) begin
      frame_q <= frame_nxt;
      b_q     <= b_nxt;
      lrclk_o <= lr_nxt;
      sdata_o <= frame_nxt[idx];
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx.
// Timing model + frame scoreboard + scenario tasks.
module tb_i2s_tx;

  localparam int W  = 16;
  localparam int SD = 2;
  localparam int FR = 4 * W * SD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk, lrclk, sdata, underrun;

  int compared = 0;
  int mismatched = 0;

  i2s_tx_if #(.W(W)) bus ();

  i2s_tx #(
    .SAMPLE_WIDTH (W),
    .SCLK_DIV     (SD)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .src        (bus.slave),
    .sclk_o     (sclk),
    .lrclk_o    (lrclk),
    .sdata_o    (sdata),
    .underrun_o (underrun)
  );

  always #5 clk = ~clk;

  // model state
  int           ecnt = 0;
  logic         m_full = 1'b0;
  logic [W-1:0] m_hold = '0;
  logic         exp_under = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] dec_log[$];

  // decoder state
  logic         prev_sclk = 1'b0;
  int           pos = 0;
  logic [W-1:0] left = '0;
  logic [W-1:0] right = '0;
  logic         lr_bad = 1'b0;

  // Timing model: frame loads at edge SD + k*FR.
  initial begin
    logic acc;
    logic ld;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        ecnt = 0;
        m_full = 1'b0;
        exp_under = 1'b0;
        exp_q.delete();
      end else begin
        ecnt = ecnt + 1;
        acc = (bus.valid === 1'b1) && !m_full;
        ld = (ecnt >= SD) && ((ecnt - SD) % FR == 0);
        if (ld) begin
          exp_q.push_back(m_full ? m_hold : '0);
          exp_under = !m_full;
          m_full = acc;
        end else begin
          exp_under = 1'b0;
          if (acc) m_full = 1'b1;
        end
        if (acc) m_hold = bus.sample;
      end
    end
  end

  // Per-cycle checks and frame decoding on SCLK rise.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sclk = 1'b0;
        pos = 0;
        lr_bad = 1'b0;
      end else begin
        compared++;
        if (underrun !== exp_under) begin
          mismatched++;
          $display("FAIL underrun_track t=%0t got %b want %b",
                   $time, underrun, exp_under);
        end
        compared++;
        if (bus.ready !== !m_full) begin
          mismatched++;
          $display("FAIL ready_track t=%0t got %b want %b",
                   $time, bus.ready, !m_full);
        end
        if (sclk === 1'b1 && prev_sclk === 1'b0) begin
          if (lrclk !== ((pos >= W - 1) && (pos <= 2 * W - 2)))
            lr_bad = 1'b1;
          if (pos < W) left = {left[W-2:0], sdata};
          else right = {right[W-2:0], sdata};
          pos++;
          if (pos == 2 * W) begin
            pos = 0;
            compared++;
            if (exp_q.size() == 0) begin
              mismatched++;
              $display("FAIL frame_unexpected t=%0t got %h",
                       $time, left);
            end else begin
              e = exp_q.pop_front();
              if (left !== e || right !== e || lr_bad) begin
                mismatched++;
                $display("FAIL frame t=%0t got L=%h R=%h lrbad=%b want %h",
                         $time, left, right, lr_bad, e);
              end
            end
            dec_log.push_back(left);
            lr_bad = 1'b0;
          end
        end
        prev_sclk = sclk;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [W-1:0] v);
    logic r;
    bit ok;
    ok = 0;
    bus.valid = 1'b1;
    bus.sample = v;
    for (int n = 0; n < 4 * FR; n++) begin
      r = bus.ready;
      @(negedge clk);
      if (r) begin
        ok = 1;
        break;
      end
    end
    bus.valid = 1'b0;
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL push_timeout got none want accept %h", v);
    end
  endtask

  task automatic wait_log(input int n, input int lim);
    for (int c = 0; c < lim && dec_log.size() < n; c++)
      @(negedge clk);
  endtask

  task automatic test_reset();
    bus.valid = 1'b0;
    bus.sample = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus.valid = 1'b1;
    bus.sample = 16'hFFFF;
    @(negedge clk);
    bus.valid = 1'b0;
    repeat (100) @(negedge clk);
    bus.valid = 1'b1;
    bus.sample = 16'h1234;
    @(negedge clk);
    bus.valid = 1'b0;
    compared++;
    if (bus.ready !== 1'b0) begin
      mismatched++;
      $display("FAIL hold_before_reset got %b want 0", bus.ready);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if ({sclk, lrclk, sdata, underrun, bus.ready} !== 5'b00001) begin
      mismatched++;
      $display("FAIL reset_outputs got %b want 00001",
               {sclk, lrclk, sdata, underrun, bus.ready});
    end
    repeat (3) @(negedge clk);
    compared++;
    if ({sclk, lrclk, sdata, underrun, bus.ready} !== 5'b00001) begin
      mismatched++;
      $display("FAIL reset_hold got %b want 00001",
               {sclk, lrclk, sdata, underrun, bus.ready});
    end
    rst_n = 1'b1;
    dec_log.delete();
    @(negedge clk);
    compared++;
    if ({underrun, sclk} !== 2'b00) begin
      mismatched++;
      $display("FAIL early_strobe got %b want 00", {underrun, sclk});
    end
    @(negedge clk);
    compared++;
    if ({underrun, sclk} !== 2'b10) begin
      mismatched++;
      $display("FAIL first_fall_2clk got %b want 10", {underrun, sclk});
    end
  endtask

  task automatic test_basic();
    bit found;
    push(16'hA5C3);
    wait_log(2, 3 * FR);
    found = 0;
    foreach (dec_log[i])
      if (dec_log[i] === 16'hA5C3) found = 1;
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL basic_a5c3 got %0d frames want A5C3 present",
               dec_log.size());
    end
  endtask

  task automatic test_underrun();
    int t[$];
    int nz;
    nz = 0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3 * FR; i++) begin
      @(negedge clk);
      if (underrun === 1'b1) t.push_back(i);
      if (sdata !== 1'b0) nz++;
    end
    compared++;
    if (t.size() != 3) begin
      mismatched++;
      $display("FAIL underrun_pulses got %0d want 3", t.size());
    end else begin
      compared++;
      if (t[1] - t[0] != FR || t[2] - t[1] != FR) begin
        mismatched++;
        $display("FAIL underrun_spacing got %0d,%0d want %0d",
                 t[1] - t[0], t[2] - t[1], FR);
      end
    end
    compared++;
    if (nz != 0) begin
      mismatched++;
      $display("FAIL underrun_sdata got %0d ones want 0", nz);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] base;
    logic [W-1:0] v;
    logic r;
    int t[$];
    int bad_iv, bad_rdy, st, n;
    bit prev_acc;
    base = 16'h1000;
    v = base;
    bad_iv = 0;
    bad_rdy = 0;
    prev_acc = 0;
    dec_log.delete();
    bus.valid = 1'b1;
    bus.sample = v;
    for (int c = 0; c < 5 * FR; c++) begin
      r = bus.ready;
      @(negedge clk);
      if (prev_acc && bus.ready !== 1'b0) bad_rdy++;
      prev_acc = r;
      if (r) begin
        t.push_back(c);
        v = v + 1'b1;
        bus.sample = v;
      end
    end
    bus.valid = 1'b0;
    n = t.size();
    compared++;
    if (n < 4) begin
      mismatched++;
      $display("FAIL b2b_count got %0d want >=4", n);
    end
    for (int i = 2; i < n; i++)
      if (t[i] - t[i-1] != FR) bad_iv++;
    compared++;
    if (bad_iv != 0) begin
      mismatched++;
      $display("FAIL b2b_interval got %0d bad want 0", bad_iv);
    end
    compared++;
    if (bad_rdy != 0) begin
      mismatched++;
      $display("FAIL b2b_ready_low got %0d bad want 0", bad_rdy);
    end
    repeat (3 * FR) @(negedge clk);
    st = -1;
    foreach (dec_log[i])
      if (st < 0 && dec_log[i] === base) st = i;
    compared++;
    if (st < 0 || st + n > dec_log.size()) begin
      mismatched++;
      $display("FAIL b2b_frames got start %0d size %0d want %0d frames",
               st, dec_log.size(), n);
    end else begin
      bad_iv = 0;
      for (int k = 0; k < n; k++)
        if (dec_log[st + k] !== base + W'(k)) bad_iv++;
      compared++;
      if (bad_iv != 0) begin
        mismatched++;
        $display("FAIL b2b_sequence got %0d bad want 0", bad_iv);
      end
    end
  endtask

  task automatic test_simultaneous();
    int l;
    for (int c = 0; c < FR + 4; c++) begin
      if (ecnt + 1 >= SD && ((ecnt + 1 - SD) % FR) == 0) break;
      @(negedge clk);
    end
    l = dec_log.size();
    bus.valid = 1'b1;
    bus.sample = 16'h5A5A;
    @(negedge clk);
    bus.valid = 1'b0;
    compared++;
    if ({underrun, bus.ready} !== 2'b10) begin
      mismatched++;
      $display("FAIL sim_load got underrun,ready=%b want 10",
               {underrun, bus.ready});
    end
    wait_log(l + 2, 3 * FR);
    compared++;
    if (dec_log.size() < l + 2) begin
      mismatched++;
      $display("FAIL sim_timeout got %0d want %0d",
               dec_log.size(), l + 2);
    end else begin
      compared++;
      if (dec_log[l] !== '0 || dec_log[l+1] !== 16'h5A5A) begin
        mismatched++;
        $display("FAIL sim_order got %h,%h want 0000,5a5a",
                 dec_log[l], dec_log[l+1]);
      end
    end
  endtask

  task automatic test_extremes();
    int l, st;
    l = dec_log.size();
    push(16'h8000);
    push(16'h7FFF);
    wait_log(l + 3, 4 * FR);
    st = -1;
    for (int i = l; i + 1 < dec_log.size(); i++)
      if (st < 0 && dec_log[i] === 16'h8000) st = i;
    compared++;
    if (st < 0) begin
      mismatched++;
      $display("FAIL ext_8000 got none want 8000 frame");
    end else begin
      compared++;
      if (dec_log[st][W-1] !== 1'b1) begin
        mismatched++;
        $display("FAIL ext_msb1 got %b want 1", dec_log[st][W-1]);
      end
      compared++;
      if (dec_log[st+1][W-1] !== 1'b0 ||
          dec_log[st+1] !== 16'h7FFF) begin
        mismatched++;
        $display("FAIL ext_7fff got %h want 7fff", dec_log[st+1]);
      end
    end
  endtask

  initial begin
    bus.valid = 1'b0;
    bus.sample = '0;
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_simultaneous();
    test_extremes();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
